// File: rtl/nova_mem_master.sv
// Nova main-memory bus initiator: sequences read, write, increment and add requests onto mm_*.
// Optional read-modify-write ops (10/11) are enabled by defining NOVA_MEM_MASTER_RMW_EN.
module nova_mem_master #(
  parameter int addr_width = 16
) (
  input  logic        pclk,
  input  logic        prst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [0:1]  req_op,
  input  logic [0:15] req_adr,
  input  logic [0:15] req_data,
  output logic        rsp_valid,
  output logic [0:15] rsp_data,
  output logic        rsp_zero,
  output logic        rsp_carry,
  output logic [0:15] mm_adr,
  output logic        mm_we,
  output logic [0:15] mm_din,
  input  logic [0:15] mm_dout
);

  typedef enum logic [1:0] {IDLE, RD, WR, RSP} state_t;

  // Bit 15 is the LSB, so the low addr_width bits are the right-justified ones.
  localparam logic [0:15] ADR_MASK = 16'hFFFF >> (16 - addr_width);

  state_t      state_q;
  logic [0:15] mm_adr_q;
  logic        mm_we_q;
  logic [0:15] mm_din_q;
  logic        carry_q;
  logic        rsp_valid_q;
  logic [0:15] rsp_data_q;
  logic        rsp_zero_q;
  logic        rsp_carry_q;

`ifdef NOVA_MEM_MASTER_RMW_EN
  logic [0:1]  op_q;
  logic [0:15] data_q;
  logic [0:15] addend;
  logic [0:16] sum;

  // op_q[1] separates add (11) from increment (10); sum[0] is the carry out.
  assign addend = op_q[1] ? data_q : 16'h0001;
  assign sum    = {1'b0, mm_dout} + {1'b0, addend};
`endif

  always_ff @(posedge pclk or negedge prst) begin
    if (!prst) begin
      state_q     <= IDLE;
      mm_adr_q    <= '0;
      mm_we_q     <= 1'b0;
      mm_din_q    <= '0;
      carry_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_zero_q  <= 1'b0;
      rsp_carry_q <= 1'b0;
`ifdef NOVA_MEM_MASTER_RMW_EN
      op_q        <= '0;
      data_q      <= '0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
      mm_we_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            mm_adr_q <= req_adr & ADR_MASK;
`ifdef NOVA_MEM_MASTER_RMW_EN
            op_q     <= req_op;
            data_q   <= req_data;
`endif
            if (req_op == 2'b01) begin
              state_q  <= WR;
              mm_we_q  <= 1'b1;
              mm_din_q <= req_data;
              carry_q  <= 1'b0;
            end else begin
              state_q  <= RD;
            end
          end
        end
        RD: begin
`ifdef NOVA_MEM_MASTER_RMW_EN
          if (op_q[0]) begin
            state_q  <= WR;
            mm_we_q  <= 1'b1;
            mm_din_q <= sum[1:16];
            carry_q  <= sum[0];
          end else
`endif
          begin
            state_q     <= RSP;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= mm_dout;
            rsp_zero_q  <= (mm_dout == 16'h0000);
            rsp_carry_q <= 1'b0;
          end
        end
        WR: begin
          state_q     <= RSP;
          rsp_valid_q <= 1'b1;
          rsp_data_q  <= mm_din_q;
          rsp_zero_q  <= (mm_din_q == 16'h0000);
          rsp_carry_q <= carry_q;
        end
        RSP:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = prst && (state_q == IDLE);
  assign mm_adr    = mm_adr_q;
  assign mm_we     = mm_we_q;
  assign mm_din    = mm_din_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_zero  = rsp_zero_q;
  assign rsp_carry = rsp_carry_q;

endmodule
